// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operation codes and datapath select values.
package control_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ADD   = 2'b00,
        SUB   = 2'b01,
        FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/control_multiciclo_if.sv
// Control bus between the multicycle controller (master) and the datapath
// (slave): instruction fields and ALU flag in, selects and enables out.
interface control_multiciclo_if;

    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i;
    logic       alu_flag0_i;
    logic       pc_write_o;
    logic       adr_src_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_write_o;
    logic [1:0] result_src_o;
    logic [1:0] alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] imm_src_o;
    logic [2:0] alu_control_o;
    logic       illegal_o;

    modport master (
        input  op_i, funct3_i, funct7b5_i, alu_flag0_i,
        output pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o,
               result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o,
               alu_control_o, illegal_o
    );

    modport slave (
        output op_i, funct3_i, funct7b5_i, alu_flag0_i,
        input  pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o,
               result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o,
               alu_control_o, illegal_o
    );

endinterface

// File: rtl/control_multiciclo_alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct3/funct7 to the 3-bit ALU code.
module alu_decoder
    import control_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            SUB:   alu_control = ALU_SUB;
            FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) can subtract; addi ignores bit 30.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/
// writeback and drives datapath selects and write enables.
module control_multiciclo
    import control_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    control_multiciclo_if.master bus
);

    state_t     state, state_next;
    aluop_t     aluop;
    logic [2:0] alu_control;
    logic       pc_write, mem_write, ir_write, reg_write, illegal;
    logic       branch_taken;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        case (bus.funct3_i)
            3'b000:  branch_taken = bus.alu_flag0_i;
            3'b001:  branch_taken = ~bus.alu_flag0_i;
            default: branch_taken = 1'b0;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path through
    // the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next        = FETCH;
        aluop             = ADD;
        pc_write          = 1'b0;
        mem_write         = 1'b0;
        ir_write          = 1'b0;
        reg_write         = 1'b0;
        illegal           = 1'b0;
        bus.adr_src_o     = ADR_PC;
        bus.result_src_o  = RES_ALUOUT;
        bus.alu_src_a_o   = SRCA_PC;
        bus.alu_src_b_o   = SRCB_RS2;
        case (state)
            FETCH: begin
                ir_write         = 1'b1;
                pc_write         = 1'b1;
                bus.alu_src_b_o  = SRCB_FOUR;
                bus.result_src_o = RES_ALU;
                state_next       = DECODE;
            end
            DECODE: begin
                bus.alu_src_a_o = SRCA_OLDPC;
                bus.alu_src_b_o = SRCB_IMM;
                case (bus.op_i)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECR;
                    OP_ITYPE:          state_next = EXECI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    default:           illegal    = 1'b1;
                endcase
            end
            MEMADR: begin
                bus.alu_src_a_o = SRCA_RS1;
                bus.alu_src_b_o = SRCB_IMM;
                state_next      = bus.op_i[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.adr_src_o = ADR_ALUOUT;
                state_next    = MEMWB;
            end
            MEMWB: begin
                bus.result_src_o = RES_MEM;
                reg_write        = 1'b1;
            end
            MEMWRITE: begin
                bus.adr_src_o = ADR_ALUOUT;
                mem_write     = 1'b1;
            end
            EXECR: begin
                bus.alu_src_a_o = SRCA_RS1;
                aluop           = FUNCT;
                state_next      = ALUWB;
            end
            EXECI: begin
                bus.alu_src_a_o = SRCA_RS1;
                bus.alu_src_b_o = SRCB_IMM;
                aluop           = FUNCT;
                state_next      = ALUWB;
            end
            ALUWB:  reg_write = 1'b1;
            BRANCH: begin
                bus.alu_src_a_o = SRCA_RS1;
                aluop           = SUB;
                pc_write        = branch_taken;
            end
            JAL: begin
                bus.alu_src_a_o = SRCA_OLDPC;
                bus.alu_src_b_o = SRCB_FOUR;
                pc_write        = 1'b1;
                state_next      = ALUWB;
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        case (bus.op_i)
            OP_STORE:  bus.imm_src_o = IMM_S;
            OP_BRANCH: bus.imm_src_o = IMM_B;
            OP_JAL:    bus.imm_src_o = IMM_J;
            default:   bus.imm_src_o = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (bus.funct3_i),
        .op5         (bus.op_i[5]),
        .funct7b5    (bus.funct7b5_i),
        .alu_control (alu_control)
    );

    assign bus.alu_control_o = alu_control;

    // Reset holds the state in FETCH, whose enables would otherwise be live.
    assign bus.pc_write_o  = pc_write  & ~rst_i;
    assign bus.mem_write_o = mem_write & ~rst_i;
    assign bus.ir_write_o  = ir_write  & ~rst_i;
    assign bus.reg_write_o = reg_write & ~rst_i;
    assign bus.illegal_o   = illegal   & ~rst_i;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: compares every control output,
// packed into one word, against hand-derived values cycle by cycle.
module tb_control_multiciclo;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    control_multiciclo_if bus ();

    control_multiciclo dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Word layout: pcw adr mw irw rw rs[1:0] sa[1:0] sb[1:0] imm[1:0] alu[2:0] ill
    function automatic logic [16:0] observed();
        return {bus.pc_write_o, bus.adr_src_o, bus.mem_write_o, bus.ir_write_o,
                bus.reg_write_o, bus.result_src_o, bus.alu_src_a_o, bus.alu_src_b_o,
                bus.imm_src_o, bus.alu_control_o, bus.illegal_o};
    endfunction

    function automatic logic [16:0] cw(logic pcw, logic adr, logic mw, logic irw, logic rw,
                                       logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                       logic [1:0] imm, logic [2:0] alu, logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [16:0] w_fetch(logic [1:0] imm);
        return cw(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction

    function automatic logic [16:0] w_decode(logic [1:0] imm);
        return cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
    endfunction

    function automatic logic [16:0] w_aluwb(logic [1:0] imm);
        return cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(logic [6:0] op, logic [2:0] f3, logic f7, logic flag);
        bus.op_i        = op;
        bus.funct3_i    = f3;
        bus.funct7b5_i  = f7;
        bus.alu_flag0_i = flag;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        #2;
        checks++;
        if (observed() !== cw(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0)) begin
            errors++;
            $display("FAIL reset_gated got=%b exp=%b", observed(),
                     cw(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (observed() !== w_fetch(2'b00)) begin
            errors++;
            $display("FAIL reset_release_fetch got=%b exp=%b", observed(), w_fetch(2'b00));
        end
    endtask

    task automatic test_lw();
        logic [16:0] exp [$];
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        exp = '{w_fetch(2'b00), w_decode(2'b00),
                cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0),
                cw(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0),
                cw(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0),
                w_fetch(2'b00)};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (observed() !== exp[i]) begin
                errors++;
                $display("FAIL lw step%0d got=%b exp=%b", i, observed(), exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_alu(string name, logic [6:0] op, logic [2:0] f3, logic f7,
                            logic [2:0] alu);
        logic [16:0] exp [$];
        logic [1:0]  sb;
        set_instr(op, f3, f7, 1'b1);
        sb = op[5] ? 2'b00 : 2'b01;
        exp = '{w_fetch(2'b00), w_decode(2'b00),
                cw(0, 0, 0, 0, 0, 2'b00, 2'b10, sb, 2'b00, alu, 0),
                w_aluwb(2'b00), w_fetch(2'b00)};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (observed() !== exp[i]) begin
                errors++;
                $display("FAIL %s step%0d got=%b exp=%b", name, i, observed(), exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_branch(string name, logic [2:0] f3, logic flag, logic pcw);
        logic [16:0] exp [$];
        set_instr(7'b1100011, f3, 1'b0, flag);
        exp = '{w_fetch(2'b10), w_decode(2'b10),
                cw(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0),
                w_fetch(2'b10)};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (observed() !== exp[i]) begin
                errors++;
                $display("FAIL %s step%0d got=%b exp=%b", name, i, observed(), exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_jal();
        logic [16:0] exp [$];
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        exp = '{w_fetch(2'b11), w_decode(2'b11),
                cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0),
                w_aluwb(2'b11), w_fetch(2'b11)};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (observed() !== exp[i]) begin
                errors++;
                $display("FAIL jal step%0d got=%b exp=%b", i, observed(), exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_illegal(string name, logic [6:0] op);
        logic [16:0] exp [$];
        set_instr(op, 3'b000, 1'b0, 1'b0);
        exp = '{w_fetch(2'b00),
                cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1),
                w_fetch(2'b00)};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (observed() !== exp[i]) begin
                errors++;
                $display("FAIL %s step%0d got=%b exp=%b", name, i, observed(), exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_mid_reset();
        logic [16:0] exp [$];
        logic [16:0] memadr, memwrite;
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        memadr   = cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
        memwrite = cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
        exp = '{w_fetch(2'b01), w_decode(2'b01), memadr, memwrite};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (observed() !== exp[i]) begin
                errors++;
                $display("FAIL sw_pre step%0d got=%b exp=%b", i, observed(), exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
        // Assert reset between edges: state and enables must drop at once.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (observed() !== cw(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0)) begin
            errors++;
            $display("FAIL mid_reset_gated got=%b exp=%b", observed(),
                     cw(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp = '{w_fetch(2'b01), w_decode(2'b01), memadr, memwrite, w_fetch(2'b01)};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (observed() !== exp[i]) begin
                errors++;
                $display("FAIL sw_post step%0d got=%b exp=%b", i, observed(), exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_alu("sub",  7'b0110011, 3'b000, 1'b1, 3'b001);
        test_alu("addi", 7'b0010011, 3'b000, 1'b1, 3'b000);
        test_alu("slt",  7'b0110011, 3'b010, 1'b0, 3'b101);
        test_alu("srl",  7'b0110011, 3'b101, 1'b0, 3'b111);
        test_alu("sll",  7'b0110011, 3'b001, 1'b0, 3'b110);
        test_alu("andi", 7'b0010011, 3'b111, 1'b0, 3'b010);
        test_alu("or",   7'b0110011, 3'b110, 1'b0, 3'b011);
        test_alu("xor",  7'b0110011, 3'b100, 1'b0, 3'b000);
        test_branch("beq_z1", 3'b000, 1'b1, 1'b1);
        test_branch("beq_z0", 3'b000, 1'b0, 1'b0);
        test_branch("bne_z1", 3'b001, 1'b1, 1'b0);
        test_branch("bne_z0", 3'b001, 1'b0, 1'b1);
        test_branch("blt_z1", 3'b100, 1'b1, 1'b0);
        test_jal();
        test_illegal("illegal_00", 7'b0000000);
        test_illegal("illegal_73", 7'b1110011);
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
